// File: rtl/parity_rx_pkg.sv
// Shared types and constants for the serial parity frame receiver.
package parity_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    PAR_E = 3'd2,
    PAR_O = 3'd3,
    STOP  = 3'd4
  } rx_state_e;

  localparam logic        START_BIT           = 1'b1;
  localparam logic        STOP_BIT            = 1'b0;
  localparam int unsigned DEFAULT_GAP_TIMEOUT = 1024;

endpackage

// File: rtl/gap_timer.sv
// Inter-bit gap timer: counts cycles since the last qualified bit.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the count (qualified bit seen, or receiver idle)
//   enable     : count this cycle
//   expired    : the count reaches GAP_TIMEOUT at the coming edge
//                (never asserted while clear is high; never asserted if GAP_TIMEOUT=0)
module gap_timer #(
  parameter int unsigned GAP_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // A limit of 0 disables the timer; LIMIT keeps the widths legal in that case.
  localparam logic        TIMEOUT_EN = (GAP_TIMEOUT != 0);
  localparam int unsigned LIMIT      = (GAP_TIMEOUT == 0) ? 1 : GAP_TIMEOUT;
  localparam int unsigned CNT_W      = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Clear wins over counting, so a bit arriving on the expiry cycle cancels the error.
  always_comb begin
    count_d = count_q;
    expired = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (enable && TIMEOUT_EN) begin
      count_d = count_q + CNT_W'(1);
      expired = (count_q == CNT_W'(LIMIT - 1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/parity_frame_receiver.sv
// Frames a qualified serial stream into start, DATA_WIDTH data bits (MSB first),
// even-parity bit, odd-parity bit and stop bit, and presents the last good frame.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   serialIn, serialValid       : serial bit and its one-cycle qualifier
//   receivedData                : data of the last good frame
//   recEvenParity, recOddParity : parity bits of the last good frame
//   frameValid                  : one-cycle pulse, outputs just updated
//   frameError                  : one-cycle pulse, bad stop bit or gap timeout
//   busy                        : receiver is inside a frame
module parity_frame_receiver
  import parity_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned GAP_TIMEOUT = DEFAULT_GAP_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serialIn,
  input  logic                  serialValid,
  output logic [DATA_WIDTH-1:0] receivedData,
  output logic                  recEvenParity,
  output logic                  recOddParity,
  output logic                  frameValid,
  output logic                  frameError,
  output logic                  busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_e_q, par_e_d;
  logic                  par_o_q, par_o_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  even_q, even_d;
  logic                  odd_q, odd_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  frame_error_q, frame_error_d;
  logic                  busy_q, busy_d;
  logic                  gap_expired;

  gap_timer #(
    .GAP_TIMEOUT(GAP_TIMEOUT)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (serialValid || (state_q == IDLE)),
    .enable (state_q != IDLE),
    .expired(gap_expired)
  );

  // Next-state and output-register logic.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_e_d       = par_e_q;
    par_o_d       = par_o_q;
    data_d        = data_q;
    even_d        = even_q;
    odd_d         = odd_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;

    if (serialValid) begin
      unique case (state_q)
        IDLE: begin
          if (serialIn == START_BIT) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d = {shift_q[DATA_WIDTH-2:0], serialIn};
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_d   = PAR_E;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        PAR_E: begin
          par_e_d = serialIn;
          state_d = PAR_O;
        end
        PAR_O: begin
          par_o_d = serialIn;
          state_d = STOP;
        end
        STOP: begin
          // A bad stop bit ends the frame; it is not treated as a new start.
          if (serialIn == STOP_BIT) begin
            data_d        = shift_q;
            even_d        = par_e_q;
            odd_d         = par_o_q;
            frame_valid_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Expiry only fires without a qualified bit, so it cannot collide with frameValid.
    if (gap_expired) begin
      state_d       = IDLE;
      bit_cnt_d     = '0;
      frame_valid_d = 1'b0;
      frame_error_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_e_q       <= 1'b0;
      par_o_q       <= 1'b0;
      data_q        <= '0;
      even_q        <= 1'b0;
      odd_q         <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_e_q       <= par_e_d;
      par_o_q       <= par_o_d;
      data_q        <= data_d;
      even_q        <= even_d;
      odd_q         <= odd_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  assign receivedData  = data_q;
  assign recEvenParity = even_q;
  assign recOddParity  = odd_q;
  assign frameValid    = frame_valid_q;
  assign frameError    = frame_error_q;
  assign busy          = busy_q;

endmodule
